// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Holds the decoded instruction for EX and detects load-use hazards.
// On a load-use hazard it inserts one bubble and raises stall to freeze PC and IF/ID.
// Honours branch/jump flush from EX and a whole-pipe stall from data memory.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [11:0]       id_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              ex_valid,
  output logic [11:0]       ex_ctrl,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              vld_p1;
  logic [11:0]       ctrl_p1;
  logic [2:0]        funct3_p1;
  logic [6:0]        funct7_p1;
  logic [4:0]        rs1_p1;
  logic [4:0]        rs2_p1;
  logic [4:0]        rd_p1;
  logic [XLEN-1:0]   pc_p1;
  logic [XLEN-1:0]   rs1_data_p1;
  logic [XLEN-1:0]   rs2_data_p1;
  logic [XLEN-1:0]   imm_p1;
  logic [CNT_W-1:0]  cnt_q;

  logic uses_rs1;
  logic uses_rs2;
  logic load_use;

  // Decode which source registers the ID instruction actually reads.
  // LUI, AUIPC, JAL and unknown opcodes read no sources, so their rs fields never stall.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode)
      OP_R, OP_STORE, OP_BR: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  // The load in EX writes a register the ID instruction needs.
  // x0 is excluded because it is never really written.
  assign load_use = vld_p1 & ctrl_p1[10] & (rd_p1 != 5'd0) & id_valid &
                    ((uses_rs1 & (rd_p1 == id_rs1)) | (uses_rs2 & (rd_p1 == id_rs2)));

  // A flush kills the ID instruction, so its hazard must not freeze the front end.
  assign stall = ext_stall | (load_use & ~flush);

  // ---- ID -> EX stage boundary (p1) ----
  // Pipeline register update.
  // Priority, highest first: flush, then external stall, then load-use bubble, then normal load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= '0;
      funct3_p1   <= '0;
      funct7_p1   <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      cnt_q       <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (ext_stall) begin
      vld_p1  <= vld_p1;
      ctrl_p1 <= ctrl_p1;
    end else if (load_use) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      cnt_q   <= sat_inc(cnt_q);
    end else begin
      vld_p1      <= id_valid;
      ctrl_p1     <= id_valid ? id_ctrl : 12'd0;
      funct3_p1   <= id_funct3;
      funct7_p1   <= id_funct7;
      rs1_p1      <= id_rs1;
      rs2_p1      <= id_rs2;
      rd_p1       <= id_rd;
      pc_p1       <= id_pc;
      rs1_data_p1 <= id_rs1_data;
      rs2_data_p1 <= id_rs2_data;
      imm_p1      <= id_imm;
    end
  end

  assign ex_valid    = vld_p1;
  assign ex_ctrl     = ctrl_p1;
  assign ex_funct3   = funct3_p1;
  assign ex_funct7   = funct7_p1;
  assign ex_rs1      = rs1_p1;
  assign ex_rs2      = rs2_p1;
  assign ex_rd       = rd_p1;
  assign ex_pc       = pc_p1;
  assign ex_rs1_data = rs1_data_p1;
  assign ex_rs2_data = rs2_data_p1;
  assign ex_imm      = imm_p1;
  assign bubble_cnt  = cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I pipeline, with load-use hazard detection and bubble insertion.
- Captures the decoder's control bundle, register-file operands, immediate, PC and register indices from ID, and presents them to EX one cycle later.
- Raises a stall to freeze PC and IF/ID on a load-use hazard.
- Honours branch/jump flush from EX and a whole-pipe external stall from the data memory.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate).
- CNT_W, 16, width of the load-use bubble performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  7  instruction[6:0].
- id_funct3  in  3  instruction[14:12].
- id_funct7  in  7  instruction[31:25].
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_ctrl  in  12  decoder bundle: [11] RegWrite, [10] MemRead, [9:8] MemWrite, [7:5] ALUOp, [4] ALUSrc, [3] Branch, [2] Jump, [1:0] ResultSrc.
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  ID datapath values.
- flush  in  1  branch taken / jump from EX; kills the instruction in ID.
- ext_stall  in  1  data memory busy; whole pipe freezes.
- ex_valid  out  1  EX holds a real instruction.
- ex_ctrl  out  12  registered id_ctrl, same bit layout.
- ex_funct3  out  3  registered.
- ex_funct7  out  7  registered.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- bubble_cnt  out  CNT_W  number of load-use bubbles inserted, saturating.

Behaviour:
- Reset (async, any time, including mid-stall): ex_valid=0, ex_ctrl=0, all ex_* data/index fields=0, bubble_cnt=0. Release is synchronous to the next clk edge.
- Latency: one cycle ID->EX when not stalled.
- Source usage, decoded from id_opcode:
  - uses_rs1 for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2 for 0110011, 0100011, 1100011.
  - All others (LUI, AUIPC, JAL, unknown) use neither.
- load_use = ex_valid & ex_ctrl[10] & (ex_rd!=0) & id_valid & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- stall = ext_stall | (load_use & ~flush).
- Per-edge update, highest priority first:
  1. flush=1: bubble (ex_valid=0, ex_ctrl=0). Applies even when ext_stall=1.
  2. ext_stall=1: all ex_* outputs hold; bubble_cnt holds.
  3. load_use=1: bubble; bubble_cnt increments.
  4. Otherwise: load all id_* fields; ex_valid=id_valid; ex_ctrl=id_valid ? id_ctrl : 0.
- Bubble: only ex_valid and ex_ctrl are forced to 0; data/index fields hold their previous values and are don't-care.
- Load-use stalls exactly one cycle. After the bubble, ex_valid=0, so load_use deasserts and the held ID instruction advances. Forwarding from MEM covers the remaining dependency.
- Back-to-back loads with dependency each produce exactly one bubble.
- x0 destination never causes a stall.
- bubble_cnt saturates at all-ones; no wrap.
- No combinational path from ex_* inputs except through registers; stall is the only combinational output.

Test Plan:
- Reset: assert rst mid-run with ex_valid=1 and load_use active -> outputs zero immediately (before clk edge), stall follows ext_stall only, bubble_cnt=0.
- Load-use: EX holds `lw x5` (ctrl[10]=1, rd=5); ID holds `add x6,x5,x7` (0110011, rs1=5) -> stall=1 for one cycle, next edge ex_valid=0 and ex_ctrl=0, bubble_cnt=1; following edge ex_rd=6, ex_ctrl=id_ctrl.
- No false hazard:
  - EX holds `lw x5`; ID holds `lui x5` (0110111) -> stall=0.
  - EX holds `lw x0`; ID holds `add` with rs1=0 -> stall=0.
  - ID holds `addi` (0010011) with rs2 field=5 -> stall=0.
- Flush priority: load_use=1 and flush=1 together -> stall=0, ex_valid=0 next edge, bubble_cnt unchanged. flush=1 with ext_stall=1 -> bubble still loaded.
- External stall: ext_stall=1 for 3 cycles with changing id_* inputs -> all ex_* outputs constant, stall=1; on release, the current id_* fields are captured on the next edge.
- Saturation: with CNT_W=4, force 17 load-use bubbles -> bubble_cnt reaches 15 and stays 15.
